bus_router: RTL and testbench
=============================

Name: bus_router

Overview:
- Single-master, NSLV-slave address router for the shared memory bus.
- Sits downstream of the I/D duplexer and feeds each slave region (bridge, RAM, ROM, peripherals).
- Decodes each request against a base/mask map and forwards it to exactly one slave.
- Tracks the single outstanding transaction and returns the slave's response. Unmapped accesses, and optionally hung slaves, answer with a fault.

Parameters:
- NSLV, 4, number of slave ports (1..8).
- SLV_BASE, {NSLV{`XLEN'h0}}, packed NSLV*`XLEN base addresses; slave i at bits [i*`XLEN +: `XLEN].
- SLV_MASK, {NSLV{`XLEN'h0}}, packed NSLV*`XLEN region masks. Slave i hits when (m_addr & ~mask_i) == base_i.
- TIMEOUT, 255, cycles BUSY may wait for s_resp before a fault response (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: synchronous, active-low; clock clk.
- m_addr  in  `XLEN  byte address, valid while m_req.
- m_w_rb  in  1  1 = write, 0 = read.
- m_acc  in  $clog2(`BUS_ACC_CNT)  access size.
- m_wdata  in  `BUS_WIDTH  write data.
- m_req  in  1  single-cycle request pulse.
- m_resp  out  1  single-cycle response pulse.
- m_rdata  out  `BUS_WIDTH  read data, valid while m_resp.
- m_fault  out  1  qualifies m_resp as an error response.
- s_addr  out  `XLEN  offset within region (m_addr & mask_sel), broadcast to all slaves.
- s_w_rb  out  1  broadcast.
- s_acc  out  $clog2(`BUS_ACC_CNT)  broadcast.
- s_wdata  out  `BUS_WIDTH  broadcast.
- s_req  out  NSLV  one-hot request pulse.
- s_resp  in  NSLV  per-slave response pulse.
- s_rdata  in  NSLV*`BUS_WIDTH  packed per-slave read data.

Behaviour:
- States:
  - IDLE: no outstanding transaction.
  - BUSY: sel register holds the target slave index.
  - FLT: unmapped access; respond with fault next cycle.
- Decode is combinational on m_addr. Multiple hits resolve to the lowest index.
- Request forwarding:
  - A mapped m_req in IDLE asserts s_req[hit] in the same cycle, zero added latency.
  - s_addr/s_w_rb/s_acc/s_wdata pass through combinationally during that cycle.
  - Next state is BUSY, sel <= hit.
- Response path in BUSY:
  - m_resp = s_resp[sel] and m_rdata = s_rdata[sel], both combinational; m_fault = 0.
  - s_resp on non-selected ports is ignored.
- Back-to-back: m_req in the same cycle as m_resp in BUSY is accepted and decoded exactly as in IDLE. This supports the duplexer's req = resp & ... issue.
- Unmapped m_req:
  - No s_req is asserted; next state is FLT.
  - FLT lasts one cycle: m_resp = 1, m_fault = 1, m_rdata = 0.
  - Then IDLE, or decode again if m_req is coincident.
- m_req in BUSY without a coincident m_resp is a protocol violation: dropped, never forwarded.
- An s_resp arriving in IDLE or FLT is dropped.
- Reset values: state = IDLE, sel = 0, s_req = 0, m_resp = 0, m_fault = 0; timeout counter = 0.
- Reset asserted mid-BUSY aborts the transaction: no m_resp is issued, and a later s_resp is dropped.
- In IDLE, the s_* payload and m_rdata are don't-care; the bench must not check them.

Optional Feature:
- Macro: BUS_ROUTER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle without s_resp[sel].
  - When count == TIMEOUT: m_resp = 1, m_fault = 1, m_rdata = 0, return to IDLE.
  - If s_resp[sel] arrives in that same cycle, the real response wins with m_fault = 0.
  - Any late slave response is dropped if it lands in IDLE.
- Undefined: no counter; BUSY waits indefinitely, and m_fault is asserted only by FLT.

Decomposition:
- Add to femto.vh:
  - BUS_ROUTER state encodings (IDLE = 0, BUSY = 1, FLT = 2).
  - Default memory map base/mask constants used to instantiate SLV_BASE/SLV_MASK.
- One sub-module, bus_addr_decoder: combinational, parameterised by NSLV/SLV_BASE/SLV_MASK. Outputs hit (1), idx ($clog2(NSLV)) and offset (`XLEN).
- The FSM, sel register, response mux and timeout counter stay in bus_router.
- Pipeline registers reuse the existing dff primitive.

Test Plan:
- Map {0x00000000/mask 0xFFFF, 0x20000000/0xFFF, ...}. Read m_addr = 0x20000010 → s_req = 0b0010 same cycle, s_addr = 0x10. Slave 1 resp 3 cycles later with rdata 0xDEADBEEF → m_resp same cycle, m_rdata = 0xDEADBEEF, m_fault = 0.
- Write to unmapped 0x90000000 → no s_req bit ever set. Next cycle m_resp = 1, m_fault = 1, m_rdata = 0.
- Back-to-back: slave 0 resp with m_req to 0x20000004 in the same cycle → m_resp pulse and s_req = 0b0010 coincide; the second transaction completes normally.
- Spurious s_resp[2] while sel = 1 in BUSY → m_resp stays 0. s_resp[2] in IDLE → m_resp stays 0.
- rstn low for 1 cycle mid-BUSY → state IDLE, all outputs 0; a subsequent slave resp produces no m_resp.
- With BUS_ROUTER_TIMEOUT_EN and TIMEOUT = 8: slave never responds → m_resp = 1, m_fault = 1 exactly 8 BUSY cycles after s_req. With the macro off, m_resp stays 0 for 1000 cycles.

Source files
------------

// File: rtl/bus_router_pkg.sv
// bus_router_pkg
//   Shared bus constants, router state encoding and the default memory map
//   used to parameterise bus_router (SLV_BASE / SLV_MASK).
//   No ports.
package bus_router_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned BUS_WIDTH   = 32;
   localparam int unsigned BUS_ACC_CNT = 4;
   localparam int unsigned ACC_W       = $clog2(BUS_ACC_CNT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FLT  = 2'd2
   } bus_router_state_t;

   // Default 4-slave map: ROM/boot, peripherals, RAM, bridge.
   localparam int unsigned DEF_NSLV = 4;
   localparam logic [DEF_NSLV*XLEN-1:0] DEF_SLV_BASE = {
      32'h8000_0000, 32'h2000_0000, 32'h2000_0000, 32'h0000_0000
   };
   localparam logic [DEF_NSLV*XLEN-1:0] DEF_SLV_MASK = {
      32'h0000_0FFF, 32'h0000_FFFF, 32'h0000_0FFF, 32'h0000_FFFF
   };

   // Index width that stays legal for a single-slave configuration.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder
//   Combinational base/mask address decoder. Slave i hits when
//   (addr & ~mask_i) == base_i; several hits resolve to the lowest index.
//   Ports:
//     addr   in  XLEN        byte address
//     hit    out 1           some slave region matches
//     idx    out IDXW        index of the matching slave
//     offset out XLEN        addr & mask of the matching slave
module bus_addr_decoder
   import bus_router_pkg::*;
#(
   parameter int unsigned           NSLV     = 4,
   parameter logic [NSLV*XLEN-1:0]  SLV_BASE = '0,
   parameter logic [NSLV*XLEN-1:0]  SLV_MASK = '0,
   localparam int unsigned          IDXW     = idx_width(NSLV)
)(
   input  logic [XLEN-1:0] addr,
   output logic            hit,
   output logic [IDXW-1:0] idx,
   output logic [XLEN-1:0] offset
);

   // Scan from the highest index down so the lowest matching slave wins.
   always_comb begin
      hit    = 1'b0;
      idx    = '0;
      offset = '0;
      for (int unsigned i = NSLV; i > 0; i--) begin
         if ((addr & ~SLV_MASK[(i-1)*XLEN +: XLEN]) == SLV_BASE[(i-1)*XLEN +: XLEN]) begin
            hit    = 1'b1;
            idx    = IDXW'(i-1);
            offset = addr & SLV_MASK[(i-1)*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/bus_router.sv
// bus_router
//   Single-master, NSLV-slave address router with one outstanding
//   transaction. Mapped requests are forwarded to one slave in the same
//   cycle; unmapped requests get a one-cycle fault response.
//   Optional macro BUS_ROUTER_TIMEOUT_EN: a BUSY transaction that sees no
//   slave response for TIMEOUT cycles completes with a fault.
//   Ports:
//     clk, rstn                 clock, synchronous active-low reset
//     m_addr/m_w_rb/m_acc/m_wdata/m_req   master request side
//     m_resp/m_rdata/m_fault    master response side
//     s_addr/s_w_rb/s_acc/s_wdata         broadcast slave payload
//     s_req  [NSLV]             one-hot slave request pulse
//     s_resp [NSLV], s_rdata    per-slave response and read data
module bus_router
   import bus_router_pkg::*;
#(
   parameter int unsigned           NSLV     = 4,
   parameter logic [NSLV*XLEN-1:0]  SLV_BASE = '0,
   parameter logic [NSLV*XLEN-1:0]  SLV_MASK = '0,
   parameter int unsigned           TIMEOUT  = 255
)(
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [XLEN-1:0]           m_addr,
   input  logic                      m_w_rb,
   input  logic [ACC_W-1:0]          m_acc,
   input  logic [BUS_WIDTH-1:0]      m_wdata,
   input  logic                      m_req,
   output logic                      m_resp,
   output logic [BUS_WIDTH-1:0]      m_rdata,
   output logic                      m_fault,
   output logic [XLEN-1:0]           s_addr,
   output logic                      s_w_rb,
   output logic [ACC_W-1:0]          s_acc,
   output logic [BUS_WIDTH-1:0]      s_wdata,
   output logic [NSLV-1:0]           s_req,
   input  logic [NSLV-1:0]           s_resp,
   input  logic [NSLV*BUS_WIDTH-1:0] s_rdata
);

   localparam int unsigned IDXW = idx_width(NSLV);

   bus_router_state_t    state;
   logic [IDXW-1:0]      sel;
   logic                 hit;
   logic [IDXW-1:0]      hit_idx;
   logic [XLEN-1:0]      hit_offset;
   logic                 sel_resp;
   logic [BUS_WIDTH-1:0] sel_rdata;
   logic                 accept;
   logic                 tmo_hit;

`ifdef BUS_ROUTER_TIMEOUT_EN
   localparam int unsigned TW = 16;
   logic [TW-1:0] tmo_cnt;
   assign tmo_hit = (state == ST_BUSY) && !sel_resp && (tmo_cnt == TW'(TIMEOUT));
`else
   assign tmo_hit = 1'b0;
`endif

   bus_addr_decoder #(
      .NSLV     (NSLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .addr   (m_addr),
      .hit    (hit),
      .idx    (hit_idx),
      .offset (hit_offset)
   );

   // Response mux for the slave captured in sel.
   always_comb begin
      sel_resp  = 1'b0;
      sel_rdata = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (sel == IDXW'(i)) begin
            sel_resp  = s_resp[i];
            sel_rdata = s_rdata[i*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   always_comb begin
      m_resp  = 1'b0;
      m_fault = 1'b0;
      m_rdata = '0;
      case (state)
         ST_BUSY: begin
            if (tmo_hit) begin
               m_resp  = 1'b1;
               m_fault = 1'b1;
            end else begin
               m_resp  = sel_resp;
               m_rdata = sel_rdata;
            end
         end
         ST_FLT: begin
            m_resp  = 1'b1;
            m_fault = 1'b1;
         end
         default: ;
      endcase
   end

   // A new request is taken whenever the router is free or is retiring its
   // transaction this cycle (response or fault), giving back-to-back issue.
   assign accept = m_req && ((state != ST_BUSY) || m_resp);

   always_comb begin
      s_req = '0;
      if (accept && hit)
         s_req[hit_idx] = 1'b1;
   end

   assign s_addr  = hit_offset;
   assign s_w_rb  = m_w_rb;
   assign s_acc   = m_acc;
   assign s_wdata = m_wdata;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= ST_IDLE;
         sel   <= '0;
`ifdef BUS_ROUTER_TIMEOUT_EN
         tmo_cnt <= '0;
`endif
      end else begin
         if (accept) begin
            if (hit) begin
               state <= ST_BUSY;
               sel   <= hit_idx;
            end else begin
               state <= ST_FLT;
            end
         end else if ((state != ST_BUSY) || m_resp) begin
            state <= ST_IDLE;
         end
`ifdef BUS_ROUTER_TIMEOUT_EN
         if (accept && hit)
            tmo_cnt <= '0;
         else if ((state == ST_BUSY) && !sel_resp)
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_bus_router.sv
module tb_bus_router;
   import bus_router_pkg::*;

   localparam int unsigned NSLV = 4;

   logic                      clk;
   logic                      rstn;
   logic [XLEN-1:0]           m_addr;
   logic                      m_w_rb;
   logic [ACC_W-1:0]          m_acc;
   logic [BUS_WIDTH-1:0]      m_wdata;
   logic                      m_req;
   logic                      m_resp;
   logic [BUS_WIDTH-1:0]      m_rdata;
   logic                      m_fault;
   logic [XLEN-1:0]           s_addr;
   logic                      s_w_rb;
   logic [ACC_W-1:0]          s_acc;
   logic [BUS_WIDTH-1:0]      s_wdata;
   logic [NSLV-1:0]           s_req;
   logic [NSLV-1:0]           s_resp;
   logic [NSLV*BUS_WIDTH-1:0] s_rdata;

   int checks   = 0;
   int failures = 0;

   bus_router #(
      .NSLV     (NSLV),
      .SLV_BASE ({32'h8000_0000, 32'h2000_0000, 32'h2000_0000, 32'h0000_0000}),
      .SLV_MASK ({32'h0000_0FFF, 32'h0000_FFFF, 32'h0000_0FFF, 32'h0000_FFFF}),
      .TIMEOUT  (8)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .m_addr  (m_addr),
      .m_w_rb  (m_w_rb),
      .m_acc   (m_acc),
      .m_wdata (m_wdata),
      .m_req   (m_req),
      .m_resp  (m_resp),
      .m_rdata (m_rdata),
      .m_fault (m_fault),
      .s_addr  (s_addr),
      .s_w_rb  (s_w_rb),
      .s_acc   (s_acc),
      .s_wdata (s_wdata),
      .s_req   (s_req),
      .s_resp  (s_resp),
      .s_rdata (s_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        w_rb;
      logic [1:0]  acc;
      logic [31:0] wdata;
      int          slv;    // expected slave, -1 = unmapped
      logic [31:0] offs;   // expected s_addr
      int          delay;  // BUSY cycles before the slave answers
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic slave_answer(input int s, input logic [31:0] d);
      s_resp = '0;
      s_resp[s] = 1'b1;
      s_rdata[s*32 +: 32] = d;
   endtask

   task automatic issue(input logic [31:0] a, input logic w);
      m_addr  = a;
      m_w_rb  = w;
      m_acc   = 2'd2;
      m_wdata = 32'hA5A5_0000 ^ a;
      m_req   = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [3:0] exp_sreq;
      exp_sreq = (v.slv >= 0) ? (4'b0001 << v.slv) : 4'b0000;
      m_addr  = v.addr;
      m_w_rb  = v.w_rb;
      m_acc   = v.acc;
      m_wdata = v.wdata;
      m_req   = 1'b1;
      #3;
      chk({tag, " s_req"}, 64'(s_req), 64'(exp_sreq));
      if (v.slv >= 0) begin
         chk({tag, " s_addr"}, 64'(s_addr), 64'(v.offs));
         chk({tag, " s_w_rb"}, 64'(s_w_rb), 64'(v.w_rb));
         chk({tag, " s_acc"}, 64'(s_acc), 64'(v.acc));
         chk({tag, " s_wdata"}, 64'(s_wdata), 64'(v.wdata));
      end
      tick;
      m_req = 1'b0;
      if (v.slv < 0) begin
         #3;
         chk({tag, " flt s_req"}, 64'(s_req), 64'h0);
         chk({tag, " flt m_resp"}, 64'(m_resp), 64'h1);
         chk({tag, " flt m_fault"}, 64'(m_fault), 64'h1);
         chk({tag, " flt m_rdata"}, 64'(m_rdata), 64'h0);
         tick;
         #3;
         chk({tag, " post-flt m_resp"}, 64'(m_resp), 64'h0);
      end else begin
         for (int d = 0; d < v.delay; d++) begin
            #3;
            chk({tag, " wait m_resp"}, 64'(m_resp), 64'h0);
            tick;
         end
         slave_answer(v.slv, v.rdata);
         #3;
         chk({tag, " m_resp"}, 64'(m_resp), 64'h1);
         chk({tag, " m_fault"}, 64'(m_fault), 64'h0);
         chk({tag, " m_rdata"}, 64'(m_rdata), 64'(v.rdata));
         tick;
         s_resp = '0;
         #3;
         chk({tag, " done m_resp"}, 64'(m_resp), 64'h0);
      end
   endtask

   initial begin
      logic seen;

      vecs[0] = '{32'h2000_0010, 1'b0, 2'd2, 32'h0000_0000, 1, 32'h0000_0010, 2, 32'hDEAD_BEEF};
      vecs[1] = '{32'h9000_0000, 1'b1, 2'd2, 32'h1234_5678, -1, 32'h0, 0, 32'h0};
      vecs[2] = '{32'h0000_ABCD, 1'b0, 2'd0, 32'h0000_0000, 0, 32'h0000_ABCD, 0, 32'h1234_5678};
      vecs[3] = '{32'h2000_1234, 1'b1, 2'd1, 32'hFEED_FACE, 2, 32'h0000_1234, 1, 32'hCAFE_0001};
      vecs[4] = '{32'h8000_0FFC, 1'b0, 2'd2, 32'h0000_0000, 3, 32'h0000_0FFC, 2, 32'h0BAD_F00D};
      vecs[5] = '{32'h8000_1000, 1'b0, 2'd2, 32'h0000_0000, -1, 32'h0, 0, 32'h0};
      vecs[6] = '{32'h0001_0000, 1'b0, 2'd2, 32'h0000_0000, -1, 32'h0, 0, 32'h0};
      vecs[7] = '{32'h2000_FFFF, 1'b0, 2'd0, 32'h0000_0000, 2, 32'h0000_FFFF, 0, 32'h5A5A_A5A5};

      rstn    = 1'b0;
      m_req   = 1'b0;
      m_addr  = '0;
      m_w_rb  = 1'b0;
      m_acc   = '0;
      m_wdata = '0;
      s_resp  = '0;
      s_rdata = '0;
      tick;
      tick;
      #3;
      chk("reset m_resp", 64'(m_resp), 64'h0);
      chk("reset m_fault", 64'(m_fault), 64'h0);
      chk("reset s_req", 64'(s_req), 64'h0);
      rstn = 1'b1;
      tick;

      for (int i = 0; i < 8; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // back-to-back: new request coincides with slave 0's response
      issue(32'h0000_0020, 1'b0);
      #3;
      chk("b2b first s_req", 64'(s_req), 64'h1);
      tick;
      m_req = 1'b0;
      #3;
      chk("b2b wait m_resp", 64'(m_resp), 64'h0);
      tick;
      slave_answer(0, 32'h1111_2222);
      issue(32'h2000_0004, 1'b1);
      #3;
      chk("b2b m_resp", 64'(m_resp), 64'h1);
      chk("b2b m_rdata", 64'(m_rdata), 64'h1111_2222);
      chk("b2b second s_req", 64'(s_req), 64'h2);
      chk("b2b s_addr", 64'(s_addr), 64'h4);
      tick;
      m_req  = 1'b0;
      s_resp = '0;
      #3;
      chk("b2b second wait", 64'(m_resp), 64'h0);
      tick;
      slave_answer(1, 32'h3333_4444);
      #3;
      chk("b2b second m_resp", 64'(m_resp), 64'h1);
      chk("b2b second m_rdata", 64'(m_rdata), 64'h3333_4444);
      tick;
      s_resp = '0;

      // back-to-back out of the fault state
      issue(32'h9000_0000, 1'b1);
      #3;
      chk("fltb2b s_req0", 64'(s_req), 64'h0);
      tick;
      issue(32'h2000_0008, 1'b0);
      #3;
      chk("fltb2b m_fault", 64'(m_fault), 64'h1);
      chk("fltb2b s_req", 64'(s_req), 64'h2);
      tick;
      m_req = 1'b0;
      slave_answer(1, 32'h0000_0055);
      #3;
      chk("fltb2b m_resp", 64'(m_resp), 64'h1);
      chk("fltb2b m_fault2", 64'(m_fault), 64'h0);
      tick;
      s_resp = '0;

      // spurious responses and a dropped request during BUSY
      issue(32'h2000_0030, 1'b0);
      tick;
      m_req = 1'b0;
      slave_answer(2, 32'h0000_0BAD);
      #3;
      chk("spur busy m_resp", 64'(m_resp), 64'h0);
      tick;
      s_resp = '0;
      issue(32'h0000_0040, 1'b0);
      #3;
      chk("busy req dropped", 64'(s_req), 64'h0);
      tick;
      m_req = 1'b0;
      slave_answer(1, 32'h0000_0077);
      #3;
      chk("spur real m_resp", 64'(m_resp), 64'h1);
      chk("spur real m_rdata", 64'(m_rdata), 64'h77);
      tick;
      slave_answer(2, 32'h0000_0BAD);
      #3;
      chk("spur idle m_resp", 64'(m_resp), 64'h0);
      tick;
      s_resp = '0;
      #3;
      chk("spur idle after", 64'(m_resp), 64'h0);
      tick;

      // reset in the middle of a transaction
      issue(32'h2000_0050, 1'b0);
      tick;
      m_req = 1'b0;
      tick;
      rstn = 1'b0;
      tick;
      rstn = 1'b1;
      #3;
      chk("rst m_resp", 64'(m_resp), 64'h0);
      chk("rst m_fault", 64'(m_fault), 64'h0);
      chk("rst s_req", 64'(s_req), 64'h0);
      tick;
      slave_answer(1, 32'h0000_0099);
      #3;
      chk("rst late m_resp", 64'(m_resp), 64'h0);
      tick;
      s_resp = '0;

`ifdef BUS_ROUTER_TIMEOUT_EN
      issue(32'h2000_0060, 1'b0);
      #3;
      chk("tmo s_req", 64'(s_req), 64'h2);
      tick;
      m_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #3;
         if (m_resp) seen = 1'b1;
         tick;
      end
      chk("tmo early m_resp", 64'(seen), 64'h0);
      #3;
      chk("tmo m_resp", 64'(m_resp), 64'h1);
      chk("tmo m_fault", 64'(m_fault), 64'h1);
      chk("tmo m_rdata", 64'(m_rdata), 64'h0);
      tick;
      slave_answer(1, 32'h0000_0101);
      #3;
      chk("tmo late m_resp", 64'(m_resp), 64'h0);
      tick;
      s_resp = '0;
      issue(32'h2000_0064, 1'b0);
      tick;
      m_req = 1'b0;
      for (int k = 0; k < 8; k++) tick;
      slave_answer(1, 32'h0000_0202);
      #3;
      chk("tmo race m_resp", 64'(m_resp), 64'h1);
      chk("tmo race m_fault", 64'(m_fault), 64'h0);
      chk("tmo race m_rdata", 64'(m_rdata), 64'h202);
      tick;
      s_resp = '0;
`else
      issue(32'h2000_0060, 1'b0);
      #3;
      chk("hang s_req", 64'(s_req), 64'h2);
      tick;
      m_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         #3;
         if (m_resp || m_fault) seen = 1'b1;
         tick;
      end
      chk("hang no m_resp", 64'(seen), 64'h0);
      slave_answer(1, 32'h0000_0303);
      #3;
      chk("hang m_resp", 64'(m_resp), 64'h1);
      chk("hang m_fault", 64'(m_fault), 64'h0);
      chk("hang m_rdata", 64'(m_rdata), 64'h303);
      tick;
      s_resp = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
